// File: rtl/ddr_pkg.sv
// Shared types and widths for the rhythm-game spawn scheduler.
//   game_state_t : top-level game FSM encoding (IDLE/PLAY/WON/LOST)
//   COLS         : number of note columns
//   SCORE_W      : width of the running score
//   COUNT_W      : width of miss count and light speed
//   popcount4    : number of set bits in a column vector
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        LOST = 2'd3
    } game_state_t;

    localparam int COLS    = 4;
    localparam int SCORE_W = 8;
    localparam int COUNT_W = 4;

    function automatic logic [2:0] popcount4(input logic [COLS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/spawn_scheduler_if.sv
// Game-side bus between the column logic and the spawn scheduler.
//   start       : one-cycle request to begin or leave a game
//   hit/empty/miss : per-column one-cycle event pulses from the columns
//   spawn       : per-column one-cycle spawn pulse, at most one bit set
//   light_speed : speed setting broadcast to all columns
//   score, misses, game_state : game status
// master = column/player side, slave = scheduler.
interface spawn_scheduler_if;
    import ddr_pkg::*;

    logic                start;
    logic [COLS-1:0]     hit;
    logic [COLS-1:0]     empty;
    logic [COLS-1:0]     miss;
    logic [COLS-1:0]     spawn;
    logic [COUNT_W-1:0]  light_speed;
    logic [SCORE_W-1:0]  score;
    logic [COUNT_W-1:0]  misses;
    game_state_t         game_state;

    modport master (
        output start, hit, empty, miss,
        input  spawn, light_speed, score, misses, game_state
    );

    modport slave (
        input  start, hit, empty, miss,
        output spawn, light_speed, score, misses, game_state
    );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0.
//   clk   : clock
//   reset : synchronous active-high, loads SEED (must be nonzero)
//   en    : advance one step this cycle
//   q     : current register value
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Game controller: runs the IDLE/PLAY/WON/LOST FSM, spawns lights on a
// pseudo-random column every SPAWN_GAP cycles while playing, and keeps
// score, miss count and light speed.
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : spawn_scheduler_if slave (start/hit/empty/miss in,
//           spawn/light_speed/score/misses/game_state out)
// LEVEL_HITS is expected to be at least COLS so one cycle of hits can
// cross at most one level boundary.
module spawn_scheduler
    import ddr_pkg::*;
#(
    parameter int         SPAWN_GAP  = 32,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         WIN_SCORE  = 200,
    parameter int         MAX_MISSES = 8,
    parameter int         LEVEL_HITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    spawn_scheduler_if.slave bus
);

    localparam int GAP_W   = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int TALLY_W = $clog2(LEVEL_HITS + COLS + 1);

    localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(SPAWN_GAP - 1);
    localparam logic [TALLY_W-1:0] TALLY_WRAP = TALLY_W'(LEVEL_HITS);
    localparam logic [SCORE_W-1:0] WIN_LIMIT  = SCORE_W'(WIN_SCORE);
    localparam logic [COUNT_W-1:0] MISS_LIMIT = COUNT_W'(MAX_MISSES);

    game_state_t         state;
    game_state_t         state_next;
    logic [7:0]          lfsr_q;
    logic [GAP_W-1:0]    gap_cnt;
    logic [1:0]          prev_col;
    logic [1:0]          cand_col;
    logic [1:0]          spawn_col;
    logic [TALLY_W-1:0]  tally;
    logic [TALLY_W-1:0]  tally_sum;
    logic                level_up;
    logic [2:0]          hit_cnt;
    logic [2:0]          empty_cnt;
    logic [2:0]          miss_cnt;
    logic signed [9:0]   score_sum;

    function automatic logic [SCORE_W-1:0] sat_score(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            return '0;
        end else if (v > 10'sd255) begin
            return '1;
        end
        return v[SCORE_W-1:0];
    endfunction

    function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W-1:0] a,
                                                      input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNT_W] ? '1 : s[COUNT_W-1:0];
    endfunction

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state == PLAY),
        .q     (lfsr_q)
    );

    assign bus.game_state = state;

    // Loss is tested first so a simultaneous win/loss ends as LOST.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.start) state_next = PLAY;
            PLAY: begin
                if (bus.misses >= MISS_LIMIT) begin
                    state_next = LOST;
                end else if (bus.score >= WIN_LIMIT) begin
                    state_next = WON;
                end
            end
            WON, LOST: if (bus.start) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The whole score delta is applied in one signed step before clamping,
    // so a hit and a miss on the same cycle net out before saturation.
    always_comb begin
        hit_cnt   = popcount4(bus.hit);
        empty_cnt = popcount4(bus.empty);
        miss_cnt  = popcount4(bus.miss);
        score_sum = $signed({2'b00, bus.score})
                  + $signed({7'b0, hit_cnt})
                  - $signed({7'b0, empty_cnt})
                  - $signed({6'b0, miss_cnt, 1'b0});
        tally_sum = tally + TALLY_W'(hit_cnt);
        level_up  = (tally_sum >= TALLY_WRAP);
        // Never spawn the same column twice in a row.
        cand_col  = lfsr_q[1:0];
        spawn_col = (cand_col == prev_col) ? cand_col + 2'd1 : cand_col;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.spawn       <= '0;
            bus.score       <= '0;
            bus.misses      <= '0;
            bus.light_speed <= '0;
            tally           <= '0;
            prev_col        <= '0;
            gap_cnt         <= GAP_RELOAD;
        end else begin
            state     <= state_next;
            bus.spawn <= '0;
            if (state == IDLE && bus.start) begin
                bus.score       <= '0;
                bus.misses      <= '0;
                bus.light_speed <= '0;
                tally           <= '0;
                gap_cnt         <= GAP_RELOAD;
            end else if (state == PLAY) begin
                bus.score  <= sat_score(score_sum);
                bus.misses <= sat_count(bus.misses, {1'b0, miss_cnt});
                // tally holds hits modulo LEVEL_HITS; a wrap is a level crossing.
                if (level_up) begin
                    tally           <= tally_sum - TALLY_WRAP;
                    bus.light_speed <= sat_count(bus.light_speed, COUNT_W'(1));
                end else begin
                    tally <= tally_sum;
                end
                if (gap_cnt == '0) begin
                    bus.spawn <= 4'b0001 << spawn_col;
                    prev_col  <= spawn_col;
                    gap_cnt   <= GAP_RELOAD;
                end else begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Self-checking bench for spawn_scheduler with SPAWN_GAP=8, WIN_SCORE=10,
// MAX_MISSES=3, LEVEL_HITS=4. Expected spawns and score/miss/speed values
// are queued when stimulus is driven and compared as the DUT produces them.
module tb_spawn_scheduler;
    import ddr_pkg::*;

    localparam int         GAP  = 8;
    localparam int         WIN  = 10;
    localparam int         MAXM = 3;
    localparam int         LVL  = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk = 1'b0;
    logic reset;

    spawn_scheduler_if bus();

    spawn_scheduler #(
        .SPAWN_GAP  (GAP),
        .LFSR_SEED  (SEED),
        .WIN_SCORE  (WIN),
        .MAX_MISSES (MAXM),
        .LEVEL_HITS (LVL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [3:0] col; } spawn_exp_t;
    typedef struct { int score; int misses; int speed; } stat_exp_t;

    spawn_exp_t exp_q[$];
    stat_exp_t  stat_q[$];
    spawn_exp_t mon_e;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         play_cyc = 0;
    bit         mon_on   = 1'b0;
    logic [3:0] last_spawn = 4'b0001;
    int         m_score, m_misses, m_hits;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spawn monitor: pops one expectation per observed pulse.
    always @(negedge clk) begin
        if (reset) begin
            last_spawn = 4'b0001;   // previous-column register resets to column 0
        end else if (mon_on && bus.spawn != 4'b0000) begin
            check_eq("spawn_onehot", 32'($countones(bus.spawn)), 32'd1);
            check_eq("spawn_repeat", 32'(bus.spawn == last_spawn), 32'd0);
            last_spawn = bus.spawn;
            if (exp_q.size() == 0) begin
                check_eq("spawn_extra", 32'(bus.spawn), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("spawn_cycle", 32'(cyc - play_cyc), 32'(mon_e.cyc));
                check_eq("spawn_col", 32'(bus.spawn), 32'(mon_e.col));
            end
        end
    end

    // Reference spawn sequence for a game started straight after reset.
    task automatic build_spawns(input int n);
        logic [7:0] l;
        logic [1:0] prev, cand, col;
        int adv;
        spawn_exp_t e;
        l = SEED; prev = 2'd0; adv = 0;
        for (int k = 1; k <= n; k++) begin
            while (adv < GAP * k - 1) begin
                l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
                adv++;
            end
            cand = l[1:0];
            col  = (cand == prev) ? cand + 2'd1 : cand;
            prev = col;
            e.cyc = GAP * k;
            e.col = 4'b0001 << col;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.hit = '0; bus.empty = '0; bus.miss = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"}, 32'(bus.game_state), 32'(IDLE));
        check_eq({tag, "_spawn"}, 32'(bus.spawn), 32'd0);
        check_eq({tag, "_score"}, 32'(bus.score), 32'd0);
        check_eq({tag, "_misses"}, 32'(bus.misses), 32'd0);
        check_eq({tag, "_speed"}, 32'(bus.light_speed), 32'd0);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        play_cyc = cyc;
        m_score = 0; m_misses = 0; m_hits = 0;
        check_eq("start_play", 32'(bus.game_state), 32'(PLAY));
    endtask

    task automatic pulse(input logic [3:0] h, input logic [3:0] e, input logic [3:0] m);
        int s;
        stat_exp_t x;
        s = m_score + $countones(h) - $countones(e) - 2 * $countones(m);
        m_score  = (s < 0) ? 0 : ((s > 255) ? 255 : s);
        m_misses = (m_misses + $countones(m) > 15) ? 15 : m_misses + $countones(m);
        m_hits   = m_hits + $countones(h);
        x.score  = m_score;
        x.misses = m_misses;
        x.speed  = (m_hits / LVL > 15) ? 15 : m_hits / LVL;
        stat_q.push_back(x);
        bus.hit = h; bus.empty = e; bus.miss = m;
        tick();
        bus.hit = '0; bus.empty = '0; bus.miss = '0;
        x = stat_q.pop_front();
        check_eq("score", 32'(bus.score), 32'(x.score));
        check_eq("misses", 32'(bus.misses), 32'(x.misses));
        check_eq("speed", 32'(bus.light_speed), 32'(x.speed));
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.hit = '0; bus.empty = '0; bus.miss = '0;
        do_reset();
        check_reset_vals("rst");

        // Spawn cadence, then reset on the edge that would carry the 4th spawn.
        start_game();
        build_spawns(3);
        mon_on = 1'b1;
        repeat (31) tick();
        check_eq("spawn_drain1", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("midrst");

        // Same column sequence must replay after reset.
        start_game();
        build_spawns(4);
        repeat (34) tick();
        check_eq("spawn_drain2", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;

        // Ten single hits win the game; speed steps at hits 4 and 8.
        do_reset();
        start_game();
        for (int i = 0; i < 10; i++) pulse(4'b0001 << (i % 4), 4'b0000, 4'b0000);
        check_eq("win_score", 32'(bus.score), 32'd10);
        check_eq("win_speed", 32'(bus.light_speed), 32'd2);
        tick();
        check_eq("won_state", 32'(bus.game_state), 32'(WON));

        // Events ignored and no spawns outside PLAY.
        bus.hit = 4'b0001; bus.empty = 4'b0010; bus.miss = 4'b0100;
        tick();
        bus.hit = '0; bus.empty = '0; bus.miss = '0;
        check_eq("won_hold_score", 32'(bus.score), 32'd10);
        check_eq("won_hold_misses", 32'(bus.misses), 32'd0);
        check_eq("won_hold_speed", 32'(bus.light_speed), 32'd2);
        repeat (GAP + 1) begin
            tick();
            check_eq("won_no_spawn", 32'(bus.spawn), 32'd0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("won_to_idle", 32'(bus.game_state), 32'(IDLE));

        // Four simultaneous hits from zero.
        start_game();
        pulse(4'b1111, 4'b0000, 4'b0000);
        check_eq("burst_score", 32'(bus.score), 32'd4);
        check_eq("burst_speed", 32'(bus.light_speed), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("start_in_play", 32'(bus.game_state), 32'(PLAY));

        // Score saturates at zero.
        repeat (3) pulse(4'b0000, 4'b0001, 4'b0000);
        check_eq("score_one", 32'(bus.score), 32'd1);
        pulse(4'b0000, 4'b0001, 4'b0001);
        check_eq("sat_zero", 32'(bus.score), 32'd0);
        check_eq("sat_misses", 32'(bus.misses), 32'd1);

        // Third miss loses the game even with a concurrent hit.
        pulse(4'b0000, 4'b0000, 4'b0001);
        pulse(4'b1111, 4'b0000, 4'b0000);
        pulse(4'b1111, 4'b0000, 4'b0000);
        pulse(4'b0001, 4'b0000, 4'b0000);
        check_eq("pre_loss_score", 32'(bus.score), 32'd9);
        check_eq("pre_loss_misses", 32'(bus.misses), 32'd2);
        pulse(4'b0001, 4'b0000, 4'b0001);
        tick();
        check_eq("lost_state", 32'(bus.game_state), 32'(LOST));
        tick();
        check_eq("lost_hold_score", 32'(bus.score), 32'd8);

        // Win and loss reached together resolve to LOST.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("lost_to_idle", 32'(bus.game_state), 32'(IDLE));
        start_game();
        pulse(4'b0000, 4'b0000, 4'b0001);
        pulse(4'b0000, 4'b0000, 4'b0001);
        pulse(4'b1111, 4'b0000, 4'b0000);
        pulse(4'b1111, 4'b0000, 4'b0000);
        pulse(4'b1111, 4'b0000, 4'b0001);
        check_eq("tie_score", 32'(bus.score), 32'd10);
        tick();
        check_eq("tie_lost", 32'(bus.game_state), 32'(LOST));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 Parameter SPAWN_GAP, default 32: cycles between consecutive spawns while playing.
REQ-002 Parameter LFSR_SEED, default 8'hA5: nonzero LFSR reset value.
REQ-003 Parameter WIN_SCORE, default 200: score at or above which the game is won.
REQ-004 Parameter MAX_MISSES, default 8: miss count at which the game is lost.
REQ-005 Parameter LEVEL_HITS, default 16: hits per light_speed increment.
REQ-006 clk  in  1  sole clock, all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin or leave a game.
REQ-009 hit  in  4  per-column one-cycle pulse: the player scored on that column.
REQ-010 empty  in  4  per-column one-cycle pulse: the player pressed with no light present.
REQ-011 miss  in  4  per-column one-cycle pulse: a light left the top of that column.
REQ-012 spawn  out  4  per-column one-cycle pulse to each column's root spawn input; at most one bit set.
REQ-013 light_speed  out  4  speed setting broadcast to all four columns.
REQ-014 score  out  8  unsigned running score.
REQ-015 misses  out  4  count of misses in the current game.
REQ-016 game_state  out  2  IDLE=0, PLAY=1, WON=2, LOST=3.

Function
REQ-017 FSM transitions: IDLE->PLAY on start; PLAY->LOST when misses>=MAX_MISSES; PLAY->WON when score>=WIN_SCORE; WON or LOST->IDLE on start.
REQ-018 If the win and loss conditions become true on the same cycle, the FSM enters LOST.
REQ-019 On IDLE->PLAY: score=0, misses=0, light_speed=0, hit tally=0, gap counter=SPAWN_GAP-1.
REQ-020 In PLAY, the gap counter decrements each cycle.
REQ-021 At gap counter 0, exactly one spawn bit pulses for one cycle and the counter reloads SPAWN_GAP-1; the first spawn occurs SPAWN_GAP cycles after entering PLAY.
REQ-022 An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every PLAY cycle and holds in all other states.
REQ-023 Candidate column is LFSR[1:0]; if it equals the previously spawned column, the spawned column is (candidate+1) mod 4.
REQ-024 Score update per cycle: +popcount(hit), -popcount(empty), -2*popcount(miss), all summed in one signed 10-bit step, then saturated to 0..255.
REQ-025 Score, misses and light_speed update one cycle after the input pulse.
REQ-026 misses += popcount(miss), saturating at 15.
REQ-027 The hit tally adds popcount(hit); each time it crosses a multiple of LEVEL_HITS, light_speed increments by 1, saturating at 15.
REQ-028 hit, empty and miss are ignored outside PLAY.
REQ-029 spawn is 0 outside PLAY; score, misses and light_speed hold their values in WON and LOST.
REQ-030 start pulses while in PLAY are ignored.

Reset
REQ-031 Reset values: game_state=IDLE, spawn=0, score=0, misses=0, light_speed=0, LFSR=LFSR_SEED, previous-column register=0, gap counter=SPAWN_GAP-1.
REQ-032 Reset asserted mid-game overrides all inputs and takes effect at the next posedge; spawn is 0 on that cycle.

Structure
REQ-033 The game_state enum and the score/count widths are defined in a shared package, ddr_pkg.
REQ-034 The LFSR is a sub-module, lfsr8, with ports clk, reset, en and q[7:0].

Verification
Bench parameters for all scenarios: SPAWN_GAP=8, WIN_SCORE=10, MAX_MISSES=3, LEVEL_HITS=4.
REQ-035 Reset, then start -> game_state=PLAY next cycle; first spawn pulse 8 cycles later; pulses every 8 cycles after that, one-hot, never the same column twice in a row.
REQ-036 10 single-bit hit pulses -> score=10, game_state=WON; light_speed=2 after hits 4 and 8.
REQ-037 hit=4'b1111 while score=0 -> score=4, light_speed=1, in one cycle.
REQ-038 score=1, then miss=4'b0001 with empty=4'b0001 -> score=0 (saturated), misses=1.
REQ-039 From misses=2 and score=9, hit=4'b0001 and miss=4'b0001 on the same cycle -> game_state=LOST.
REQ-040 Reset asserted mid-PLAY after 3 spawns -> all outputs equal REQ-031 values; a following start replays the identical spawn column sequence.
